uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `UART_transmitter` among `NUM_REQ` byte-producing clients. The block arbitrates pending requests, captures the winner's byte and pulses the transmitter's `start`. It holds `data_in` stable for the whole frame and enforces the frame spacing, because the transmitter exposes no busy flag. It also drives the transmitter's active-high `enable` (synchronous clear) from the system reset.

## Interface
- `NUM_REQ`, 4: number of requesters, 2–8.
- `FRAME_CYCLES`, 14: minimum spacing, in cycles, between consecutive `tx_start` pulses. One transmitter frame lasts 14 cycles, counted from the cycle `start` is sampled back to IDLE.
- `clk` input 1: rising-edge clock, shared with the transmitter.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: bit i set = requester i has a byte pending.
- `req_data` input 8*NUM_REQ: byte of requester i in bits [8i+7:8i].
- `req_ready` output NUM_REQ: one-hot. Bit i high = requester i's byte accepted this cycle.
- `tx_enable` output 1: drives transmitter `enable`; 1 holds the transmitter idle.
- `tx_start` output 1: drives transmitter `start`; single-cycle pulse.
- `tx_data` output 8: drives transmitter `data_in`.
- `grant_id` output $clog2(NUM_REQ): index of the requester whose byte is on `tx_data`.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - FLUSH: entered on reset; `tx_enable`=1; lasts one cycle after `rst_n` release, then IDLE.
  - IDLE: no frame in flight.
  - LAUNCH: `tx_start`=1.
  - WAIT: frame in flight; counter running.
- Arbitration in IDLE, combinational from the current `req_valid`:
  - Winner w gets `req_ready[w]`=1 that same cycle. A transfer happens when `req_valid[i]` & `req_ready[i]`.
  - On that edge: `tx_data` <= byte w, `grant_id` <= w, state -> LAUNCH.
- No `req_valid` in IDLE: stay in IDLE, all `req_ready`=0.
- `req_ready` is 0 in every state other than IDLE, including FLUSH.
- LAUNCH -> WAIT unconditionally. Frame counter loads FRAME_CYCLES-2.
- WAIT: counter decrements each cycle; at 1 -> IDLE.
- `tx_data`/`grant_id` hold from capture until the next capture, never in between.
- Round-robin (default): the search starts at `grant_id`+1 mod NUM_REQ. It wraps from NUM_REQ-1 to 0. After reset the pointer is NUM_REQ-1, so index 0 has first priority.
- `req_valid` dropping before a grant is legal; the request is simply not taken.
- Changes to `req_data` of a non-granted requester have no effect.
- Reset values:
  - `tx_enable`=1, `tx_start`=0, `tx_data`=0, `grant_id`=0, `req_ready`=0, `busy`=1.
  - state FLUSH, counter 0, round-robin pointer NUM_REQ-1.
- Reset asserted mid-frame:
  - Outputs take reset values immediately (asynchronous).
  - The transmitter is cleared on the next clock via `tx_enable`.
  - The in-flight byte is lost; the requester is not notified.

## Timing
- Handshake in IDLE cycle T; `tx_start` high in T+1.
- The transmitter samples `start` at the end of T+1 and `data_in` during T+2. `tx_data` is stable from T+1 until at least T+T_next.
- Earliest next handshake: T+FRAME_CYCLES. Earliest next `tx_start`: T+1+FRAME_CYCLES.
- With continuous requests, `tx_start` pulses are exactly FRAME_CYCLES apart (default 14).
- `busy`: 0 in T, 1 in T+1 … T+FRAME_CYCLES-1.
- Reset release: `rst_n` rises before edge E. FLUSH holds through E. `tx_enable` drops after E+1. The first grant is possible in the cycle after E+1.
- `req_ready` has a combinational path from `req_valid`. All other outputs are registered.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index with `req_valid` set wins.
  - The round-robin pointer is not implemented, and starvation of high indices is accepted.
- Macro undefined: round-robin as above.
- Timing and handshake behaviour are identical in both builds.

## Test plan
- Reset, then a single request: `req_valid`=4'b0100, data 8'hA5.
  - `req_ready`=4'b0100 for one cycle; `tx_start` next cycle; `tx_data`=8'hA5; `grant_id`=2.
  - The line carries 0, A5 MSB-first, parity 0, stop 1.
- All four requesters held valid with bytes 8'h10–8'h13:
  - Grants in order 0,1,2,3,0.
  - `tx_start` pulses exactly 14 cycles apart.
  - `tx_data` never changes between pulses.
- Fixed-priority build, `req_valid`=4'b1111 held:
  - Requester 0 is granted every frame; requesters 1–3 get no `req_ready`.
- Requester 1 drops `req_valid` during WAIT; requester 3 stays valid:
  - The next grant goes to requester 3; requester 1 gets no `req_ready`.
- `rst_n` pulsed low 5 cycles after `tx_start`:
  - `tx_start`=0 and `tx_enable`=1 immediately; transmitter output returns to 1.
  - `tx_enable` stays high one extra cycle after release.
  - The first new grant is exactly two cycles after release.
- Byte parity sweep through requester 0: data 8'h00, 8'hFF, 8'h01, 8'h80.
  - Parity bits sent: 0, 0, 1, 1.
  - Each frame is 11 bits, spacing 14 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester-side handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one busy-less UART transmitter among NUM_REQ byte clients
// UART_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int FRAME_CYCLES = 14,
  localparam int IDW          = $clog2(NUM_REQ),
  localparam int CW           = $clog2(FRAME_CYCLES) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   req,
  output logic               tx_enable,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic             flush_done;
  logic [CW-1:0]    frame_cnt;
  logic [IDW-1:0]   win;
  logic             found;
  logic             take;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last assignment.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req.req_valid[i]) begin
        win   = IDW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;

  // Scan offsets far-to-near from rr_ptr+1 so the nearest valid index wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    idx   = 0;
    idx_w = '0;
    win   = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = idx[IDW-1:0];
      if (req.req_valid[idx_w]) begin
        win   = idx_w;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDW'(NUM_REQ - 1);
    end else if (take) begin
      rr_ptr <= win;
    end
  end
`endif

  assign take = (state == S_IDLE) && found;

  always_comb begin
    state_nxt     = state;
    req.req_ready = '0;
    case (state)
      S_FLUSH:  if (flush_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (found) begin
          state_nxt     = S_LAUNCH;
          req.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (frame_cnt == CW'(1)) state_nxt = S_IDLE;
      default:  state_nxt = S_FLUSH;
    endcase
  end

  // Outputs are registered off next state so they change cleanly at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FLUSH;
      flush_done <= 1'b0;
      frame_cnt  <= '0;
      tx_data    <= '0;
      grant_id   <= '0;
      tx_enable  <= 1'b1;
      tx_start   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == S_FLUSH);
      tx_enable  <= (state_nxt == S_FLUSH);
      tx_start   <= (state_nxt == S_LAUNCH);
      busy       <= (state_nxt != S_IDLE);
      if (state == S_LAUNCH) begin
        frame_cnt <= CW'(FRAME_CYCLES - 2);
      end else if (state == S_WAIT) begin
        frame_cnt <= frame_cnt - CW'(1);
      end
      if (take) begin
        tx_data  <= req.req_data[{win, 3'b000} +: 8];
        grant_id <= win;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable, tx_start, busy;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int         vectors = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .tx_enable (tx_enable),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic reset_dut;
    bus.req_valid = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_ready(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic drain;
    int n;
    bus.req_valid = '0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got %b want 0", busy); end
  endtask

  task automatic test_reset;
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL reset_tx_enable got %b want 1", tx_enable); end
    vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    rst_n = 1'b1;
    tick();
    vectors++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL flush_hold_tx_enable got %b want 1", tx_enable); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_hold_busy got %b want 1", busy); end
    tick();
    vectors++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL flush_done_tx_enable got %b want 0", tx_enable); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_done_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    int n;
    bus.req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req_valid = 4'b0100;
    #1;
    vectors++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    tick();
    vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
    vectors++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
    vectors++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
    vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_launch got %b want 0000", bus.req_ready); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    bus.req_valid = '0;
    tick();
    vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got %b want 0", tx_start); end
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    vectors++; if (n != 12) begin errors++; $display("FAIL single_busy_len got %0d want 12", n); end
    vectors++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %h want a5", tx_data); end
  endtask

  task automatic test_round_robin;
    logic       ok;
    logic [3:0] exp_rdy;
    logic [7:0] exp_data;
    int         prev;
    prev = 0;
    reset_dut();
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_rdy  = 4'b0001 << (i % 4);
      exp_data = 8'(16 + (i % 4));
      wait_ready(20, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL rr_wait_%0d got timeout want ready", i); end
      vectors++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready_%0d got %b want %b", i, bus.req_ready, exp_rdy); end
      tick();
      vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rr_start_%0d got %b want 1", i, tx_start); end
      vectors++; if (grant_id !== 2'(i % 4)) begin errors++; $display("FAIL rr_grant_%0d got %0d want %0d", i, grant_id, i % 4); end
      vectors++; if (tx_data !== exp_data) begin errors++; $display("FAIL rr_data_%0d got %h want %h", i, tx_data, exp_data); end
      if (i > 0) begin
        vectors++; if (cyc - prev != 14) begin errors++; $display("FAIL rr_spacing_%0d got %0d want 14", i, cyc - prev); end
      end
      prev = cyc;
      for (int j = 0; j < 12; j++) begin
        tick();
        vectors++;
        if (tx_data !== exp_data || tx_start !== 1'b0) begin
          errors++; $display("FAIL rr_hold_%0d_%0d got data %h start %b want %h 0", i, j, tx_data, tx_start, exp_data);
        end
      end
    end
    drain();
  endtask

  task automatic test_fixed;
    logic ok;
    reset_dut();
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_ready(20, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL fixed_wait_%0d got timeout want ready", i); end
      vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL fixed_ready_%0d got %b want 0001", i, bus.req_ready); end
      tick();
      vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL fixed_grant_%0d got %0d want 0", i, grant_id); end
      vectors++; if (tx_data !== 8'h10) begin errors++; $display("FAIL fixed_data_%0d got %h want 10", i, tx_data); end
    end
    drain();
  endtask

  task automatic test_drop;
    logic ok;
    reset_dut();
    bus.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    bus.req_valid = 4'b1011;
    wait_ready(20, ok);
    vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL drop_first_ready got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1000;
    tick();
    wait_ready(20, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL drop_wait got timeout want ready"); end
    vectors++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL drop_ready got %b want 1000", bus.req_ready); end
    tick();
    vectors++; if (grant_id !== 2'd3) begin errors++; $display("FAIL drop_grant got %0d want 3", grant_id); end
    vectors++; if (tx_data !== 8'hC3) begin errors++; $display("FAIL drop_data got %h want c3", tx_data); end
    drain();
  endtask

  task automatic test_mid_reset;
    logic ok;
    reset_dut();
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h5A};
    bus.req_valid = 4'b0001;
    wait_ready(20, ok);
    tick();
    vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL mid_first_start got %b want 1", tx_start); end
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_start got %b want 0", tx_start); end
    vectors++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL mid_enable got %b want 1", tx_enable); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", tx_data); end
    vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", bus.req_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    #1;
    vectors++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL mid_rel_enable got %b want 1", tx_enable); end
    vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rel_ready got %b want 0000", bus.req_ready); end
    tick();
    #1;
    vectors++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL mid_rel2_enable got %b want 0", tx_enable); end
    vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rel2_ready got %b want 0001", bus.req_ready); end
    tick();
    vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL mid_restart got %b want 1", tx_start); end
    vectors++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL mid_redata got %h want 5a", tx_data); end
    drain();
  endtask

  task automatic test_parity;
    logic       ok;
    logic [7:0] vals [4];
    logic       par  [4];
    int         prev;
    vals = '{8'h00, 8'hFF, 8'h01, 8'h80};
    par  = '{1'b0, 1'b0, 1'b1, 1'b1};
    prev = 0;
    reset_dut();
    bus.req_data  = {24'h0, vals[0]};
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wait_ready(20, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL par_wait_%0d got timeout want ready", i); end
      tick();
      vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL par_start_%0d got %b want 1", i, tx_start); end
      vectors++; if (tx_data !== vals[i]) begin errors++; $display("FAIL par_data_%0d got %h want %h", i, tx_data, vals[i]); end
      vectors++; if ((^tx_data) !== par[i]) begin errors++; $display("FAIL par_bit_%0d got %b want %b", i, ^tx_data, par[i]); end
      if (i > 0) begin
        vectors++; if (cyc - prev != 14) begin errors++; $display("FAIL par_spacing_%0d got %0d want 14", i, cyc - prev); end
      end
      prev = cyc;
      if (i < 3) bus.req_data[7:0] = vals[i + 1];
      else bus.req_valid = '0;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    test_fixed();
`else
    test_round_robin();
`endif
    test_drop();
    test_mid_reset();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
